// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration table sequencer.
package i2c_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_WAIT_END,
    S_CHECK,
    S_GAP,
    S_DONE,
    S_FAIL
  } state_t;

  // Table word layout: {slave addr, sub addr, data hi, data lo}
  localparam int unsigned SLAVE_HI = 31;
  localparam int unsigned SLAVE_LO = 24;
  localparam int unsigned SUB_HI   = 23;
  localparam int unsigned SUB_LO   = 16;
  localparam int unsigned DATA_HI  = 15;
  localparam int unsigned DATA_LO  = 0;

  localparam logic [15:0] TIMEOUT_CYCLES = 16'd1024;

endpackage

// File: rtl/i2c_cfg_gap_timer.sv
// Shared down-counter for the inter-transfer gap and the transfer watchdog.
module i2c_cfg_gap_timer (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] value,
  output logic        zero
);

  logic [15:0] count;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - 16'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks a table of 32-bit I2C words through the bit engine with NACK retry.
// Optional watchdog on RUN/WAIT_END enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned GAP_CYCLES  = 8
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        START,
  input  logic        ABORT,
  output logic [7:0]  TBL_ADDR,
  input  logic [31:0] TBL_DATA,
  output logic [31:0] I2C_DATA,
  output logic        GO,
  input  logic        END,
  input  logic        ACK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [7:0]  ERR_INDEX
);

  localparam logic [15:0] GAP_LOAD    = 16'(GAP_CYCLES - 1);
  localparam logic [7:0]  LAST_INDEX  = 8'(NUM_ENTRIES);
  localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRY);

  state_t      state;
  logic [7:0]  index;
  logic [3:0]  retry;
  logic        arm_cnt;
  logic        tmr_load;
  logic        tmr_en;
  logic        tmr_zero;
  logic [15:0] tmr_value;

  // GAP and watchdog never overlap, so one counter serves both.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_value = GAP_LOAD;
    case (state)
      S_CHECK: tmr_load = 1'b1;
      S_GAP:   tmr_en   = 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
      S_ARM: begin
        tmr_load  = 1'b1;
        tmr_value = TIMEOUT_CYCLES - 16'd1;
      end
      S_RUN, S_WAIT_END: tmr_en = 1'b1;
`endif
      default: ;
    endcase
  end

  i2c_cfg_gap_timer u_timer (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .load  (tmr_load),
    .en    (tmr_en),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      index     <= '0;
      retry     <= '0;
      arm_cnt   <= 1'b0;
      TBL_ADDR  <= '0;
      I2C_DATA  <= '0;
      GO        <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERROR     <= 1'b0;
      ERR_INDEX <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            DONE      <= 1'b0;
            ERROR     <= 1'b0;
            ERR_INDEX <= '0;
            index     <= '0;
            retry     <= '0;
            TBL_ADDR  <= '0;
            BUSY      <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          I2C_DATA <= {TBL_DATA[SLAVE_HI:SLAVE_LO], TBL_DATA[SUB_HI:SUB_LO],
                       TBL_DATA[DATA_HI:DATA_LO]};
          arm_cnt  <= 1'b0;
          state    <= S_ARM;
        end
        S_ARM: begin
          if (arm_cnt) begin
            GO    <= 1'b1;
            state <= S_RUN;
          end else begin
            arm_cnt <= 1'b1;
          end
        end
        S_RUN: begin
`ifdef I2C_SEQ_TIMEOUT_EN
          if (tmr_zero) begin
            GO    <= 1'b0;
            state <= S_FAIL;
          end else if (!END) begin
            state <= S_WAIT_END;
          end
`else
          if (!END) state <= S_WAIT_END;
`endif
        end
        S_WAIT_END: begin
`ifdef I2C_SEQ_TIMEOUT_EN
          if (tmr_zero) begin
            GO    <= 1'b0;
            state <= S_FAIL;
          end else if (END) begin
            GO    <= 1'b0;
            state <= S_CHECK;
          end
`else
          if (END) begin
            GO    <= 1'b0;
            state <= S_CHECK;
          end
`endif
        end
        S_CHECK: begin
          if (!ACK) begin
            retry <= '0;
            index <= index + 8'd1;
            state <= S_GAP;
          end else if (retry < RETRY_LIMIT) begin
            retry <= retry + 4'd1;
            state <= S_GAP;
          end else begin
            state <= S_FAIL;
          end
        end
        S_GAP: begin
          if (tmr_zero) begin
            if (ABORT) begin
              state <= S_FAIL;
            end else if (index == LAST_INDEX) begin
              state <= S_DONE;
            end else begin
              TBL_ADDR <= index;
              state    <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        S_FAIL: begin
          ERROR     <= 1'b1;
          ERR_INDEX <= index;
          BUSY      <= 1'b0;
          GO        <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Randomized bench for i2c_cfg_sequencer against a table-level reference model.
`timescale 1ns/1ps
module tb_i2c_cfg_sequencer;

  localparam int NUM  = 3;
  localparam int MAXR = 3;
  localparam int GAP  = 4;

  logic        CLOCK = 1'b0;
  logic        RESET, START, ABORT, GO, END, ACK, BUSY, DONE, ERROR;
  logic [7:0]  TBL_ADDR, ERR_INDEX;
  logic [31:0] TBL_DATA, I2C_DATA;

  logic [31:0] tbl [0:255];
  int          total = 0;
  int          bad   = 0;
  int          nack_e = -1;
  int          nack_left = 0;
  bit          stall = 1'b0;
  logic [31:0] sent_w [$];
  int          gaps [$];
  int          exp_q [$];
  bit          exp_err;
  int          exp_idx;

  i2c_cfg_sequencer #(
    .NUM_ENTRIES (NUM),
    .MAX_RETRY   (MAXR),
    .GAP_CYCLES  (GAP)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .START     (START),
    .ABORT     (ABORT),
    .TBL_ADDR  (TBL_ADDR),
    .TBL_DATA  (TBL_DATA),
    .I2C_DATA  (I2C_DATA),
    .GO        (GO),
    .END       (END),
    .ACK       (ACK),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERROR     (ERROR),
    .ERR_INDEX (ERR_INDEX)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) TBL_DATA <= tbl[TBL_ADDR];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Records each word seen at a GO rise and the GO-low run between transfers.
  initial begin : monitor
    logic go_prev;
    int   low;
    go_prev = 1'b0;
    low = -1;
    forever begin
      @(negedge CLOCK);
      if (GO === 1'b1 && !go_prev) begin
        if (low >= 0) gaps.push_back(low);
        sent_w.push_back(I2C_DATA);
      end else if (GO !== 1'b1) begin
        if (go_prev) low = 1;
        else if (low >= 0) low++;
      end
      if (BUSY !== 1'b1) low = -1;
      go_prev = (GO === 1'b1);
    end
  end

  // Bit-engine model: END falls after a random delay, rises later with ACK.
  initial begin : engine
    END = 1'b1;
    ACK = 1'b0;
    forever begin
      @(negedge CLOCK);
      if (GO === 1'b1 && !stall) begin
        int e;
        bit nk;
        e  = int'(I2C_DATA[7:0]);
        nk = (e == nack_e) && (nack_left > 0);
        if (nk) nack_left--;
        repeat ($urandom_range(3, 1)) @(negedge CLOCK);
        END = 1'b0;
        repeat ($urandom_range(6, 1)) @(negedge CLOCK);
        ACK = nk;
        END = 1'b1;
      end
    end
  end

  task automatic fill_table();
    logic [31:0] r;
    for (int i = 0; i < NUM; i++) begin
      r = $urandom();
      tbl[i] = {r[31:8], 8'(i)};
    end
  endtask

  task automatic build_model(input int ne, input int nn, input bit ab);
    int n;
    exp_q.delete();
    exp_err = 1'b0;
    exp_idx = 0;
    for (int e = 0; e < NUM; e++) begin
      n = (e == ne) ? nn : 0;
      for (int a = 0; a <= n && a <= MAXR; a++) begin
        exp_q.push_back(e);
        if (ab) break;
      end
      if (ab) begin
        exp_err = 1'b1;
        exp_idx = (n == 0) ? e + 1 : e;
        return;
      end
      if (n > MAXR) begin
        exp_err = 1'b1;
        exp_idx = e;
        return;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge CLOCK);
    START = 1'b1;
    @(negedge CLOCK);
    START = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (BUSY === 1'b1 && n < 20000) begin
      @(negedge CLOCK);
      n++;
    end
    check_val({tag, "_idle"}, {31'd0, BUSY}, 32'd0);
  endtask

  task automatic run_case(input string tag, input int ne, input int nn, input bit ab,
                          input bit restart);
    int n;
    int m;
    fill_table();
    build_model(ne, nn, ab);
    nack_e    = ne;
    nack_left = nn;
    sent_w.delete();
    gaps.delete();
    pulse_start();
    check_val({tag, "_start_flags"}, {29'd0, BUSY, DONE, ERROR}, 32'b100);
    if (ab) begin
      n = 0;
      while (GO !== 1'b1 && n < 200) begin
        @(negedge CLOCK);
        n++;
      end
      ABORT = 1'b1;
    end
    if (restart) begin
      repeat (9) @(negedge CLOCK);
      START = 1'b1;
      @(negedge CLOCK);
      START = 1'b0;
    end
    wait_idle(tag);
    ABORT = 1'b0;
    repeat (20) @(negedge CLOCK);
    check_val({tag, "_nsent"}, sent_w.size(), exp_q.size());
    m = (sent_w.size() < exp_q.size()) ? sent_w.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check_val($sformatf("%s_word%0d", tag, i), sent_w[i], tbl[exp_q[i]]);
    check_val({tag, "_ngaps"}, gaps.size(), (exp_q.size() > 0) ? exp_q.size() - 1 : 0);
    foreach (gaps[i])
      check_val($sformatf("%s_gap%0d", tag, i), gaps[i], GAP + 5);
    check_val({tag, "_status"}, {29'd0, DONE, ERROR, BUSY}, {29'd0, !exp_err, exp_err, 1'b0});
    if (exp_err) check_val({tag, "_err_index"}, ERR_INDEX, exp_idx);
  endtask

  initial begin : main
    int n;
    int hi;
    for (int i = 0; i < 256; i++) tbl[i] = '0;
    RESET = 1'b0;
    START = 1'b0;
    ABORT = 1'b0;
    repeat (2) @(negedge CLOCK);
    check_val("reset_outs", {12'd0, GO, BUSY, DONE, ERROR, ERR_INDEX, TBL_ADDR}, 32'd0);
    check_val("reset_data", I2C_DATA, 32'd0);
    RESET = 1'b1;

    run_case("basic", -1, 0, 1'b0, 1'b0);
    run_case("retry1", 1, 2, 1'b0, 1'b0);
    run_case("fail2", 2, 100, 1'b0, 1'b0);
    run_case("abort0", -1, 0, 1'b1, 1'b0);

    fill_table();
    nack_e = -1;
    pulse_start();
    n = 0;
    while (END !== 1'b0 && n < 500) begin
      @(negedge CLOCK);
      n++;
    end
    @(negedge CLOCK);
    check_val("rst_in_transfer_go", {31'd0, GO}, 32'd1);
    RESET = 1'b0;
    @(negedge CLOCK);
    check_val("rst_mid_outs", {12'd0, GO, BUSY, DONE, ERROR, ERR_INDEX, TBL_ADDR}, 32'd0);
    check_val("rst_mid_data", I2C_DATA, 32'd0);
    RESET = 1'b1;
    n = 0;
    while (END !== 1'b1 && n < 500) begin
      @(negedge CLOCK);
      n++;
    end
    repeat (3) @(negedge CLOCK);
    check_val("rst_stays_idle", {30'd0, BUSY, GO}, 32'd0);
    run_case("after_rst", -1, 0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++)
      run_case($sformatf("rand%0d", k), $urandom_range(2, 0), $urandom_range(5, 0), 1'b0,
               (k % 2) == 1);

`ifdef I2C_SEQ_TIMEOUT_EN
    stall = 1'b1;
    fill_table();
    pulse_start();
    n = 0;
    while (GO !== 1'b1 && n < 200) begin
      @(negedge CLOCK);
      n++;
    end
    hi = 0;
    while (GO === 1'b1 && hi < 3000) begin
      hi++;
      @(negedge CLOCK);
    end
    check_val("wdog_go_cycles", hi, 1024);
    wait_idle("wdog");
    check_val("wdog_error", {31'd0, ERROR}, 32'd1);
    check_val("wdog_err_index", ERR_INDEX, 32'd0);
    stall = 1'b0;
`else
    hi = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_cfg_sequencer.md
I2C_CFG_SEQUENCER -- requirements
Module: i2c_cfg_sequencer

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, 16, number of 32-bit table words to send (1..255).
REQ-002 SHALL have parameter MAX_RETRY, 3, retries per entry after a NACK (0..15).
REQ-003 SHALL have parameter GAP_CYCLES, 8, idle CLOCK cycles between transfers (1..255).
REQ-004 SHALL have port CLOCK, input, 1, transfer clock shared with the I2C bit engine; reset RESET, asynchronous, active-low.
REQ-005 SHALL have port RESET, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port START, input, 1, single-cycle pulse that begins a table run.
REQ-007 SHALL have port ABORT, input, 1, level that stops the run at the next transfer boundary.
REQ-008 SHALL have port TBL_ADDR, output, 8, table read address.
REQ-009 SHALL have port TBL_DATA, input, 32, table word {slave addr, sub addr, data hi, data lo}, valid 1 cycle after TBL_ADDR.
REQ-010 SHALL have ports I2C_DATA (output, 32), GO (output, 1), END (input, 1) and ACK (input, 1, high = NACK seen), connecting to the bit engine.
REQ-011 SHALL have ports BUSY, DONE, ERROR (output, 1 each) and ERR_INDEX (output, 8), giving run status and the failing entry.

Function
REQ-012 SHALL implement states IDLE, FETCH, LOAD, ARM, RUN, WAIT_END, CHECK, GAP, DONE, FAIL.
REQ-013 SHALL, in IDLE, on START: clear DONE/ERROR, set index=0, BUSY=1, go to FETCH; START while BUSY is ignored.
REQ-014 SHALL, in FETCH, drive TBL_ADDR=index for one cycle, then go to LOAD.
REQ-015 SHALL, in LOAD, register TBL_DATA into I2C_DATA and go to ARM; I2C_DATA holds stable until the next LOAD.
REQ-016 SHALL, in ARM, hold GO=0 for exactly 2 cycles so the engine restarts its bit counter, then go to RUN.
REQ-017 SHALL, in RUN, drive GO=1 and wait for END=0; at that point go to WAIT_END.
REQ-018 SHALL, in WAIT_END, keep GO=1 and wait for END=1; at that point go to CHECK.
REQ-019 SHALL, in CHECK, sample ACK: on 0, clear the retry count, index+1 and go to GAP; on 1 with retries<MAX_RETRY, retry+1, keep index and go to GAP; otherwise go to FAIL.
REQ-020 SHALL, in GAP, count GAP_CYCLES with GO=0, then go to FETCH, or to DONE if index==NUM_ENTRIES.
REQ-021 SHALL, with ABORT=1 when GAP ends, go to FAIL with ERR_INDEX=index; ABORT SHALL NOT interrupt RUN/WAIT_END.
REQ-022 SHALL, in DONE, pulse DONE=1 for one cycle, BUSY=0, return to IDLE; DONE flag sticky until next START.
REQ-023 SHALL, in FAIL, set ERROR=1 (sticky until next START), ERR_INDEX=index, BUSY=0, GO=0, return to IDLE.
REQ-024 SHALL keep the index 8 bits wide and never wrap past NUM_ENTRIES; with NUM_ENTRIES=1 the run is a single transfer.

Reset
REQ-025 SHALL, on RESET=0, force IDLE, GO=0, BUSY=0, DONE=0, ERROR=0, ERR_INDEX=0, TBL_ADDR=0, I2C_DATA=0, and clear retry/gap/index counters.
REQ-026 SHALL, on reset during a transfer, resume only after a new START; no partial transfer continues.

Configuration
REQ-027 SHALL, with I2C_SEQ_TIMEOUT_EN defined, run a 16-bit watchdog in RUN+WAIT_END and go to FAIL when 1024 cycles elapse without END completing.
REQ-028 SHALL, without I2C_SEQ_TIMEOUT_EN, have no watchdog logic; RUN/WAIT_END wait indefinitely.

Structure
REQ-029 SHALL place the state enumeration, the 32-bit word field offsets (slave 31:24, sub 23:16, data 15:0) and the timeout constant in package i2c_cfg_pkg.
REQ-030 SHALL use a single sub-module, i2c_cfg_gap_timer, for the GAP and watchdog down-counting.

Verification
REQ-031 SHALL cover NUM_ENTRIES=3, engine model always ACKs, START pulse -> three transfers of words 0,1,2 on I2C_DATA, DONE pulse, ERROR=0.
REQ-032 SHALL cover the model NACKing entry 1 twice then ACKing, MAX_RETRY=3 -> entry 1 sent 3 times, DONE, ERROR=0.
REQ-033 SHALL cover the model NACKing entry 2 always, MAX_RETRY=3 -> 4 attempts, ERROR=1, ERR_INDEX=2, BUSY=0.
REQ-034 SHALL cover ABORT raised mid-transfer of entry 0 -> entry 0 completes, FAIL with ERR_INDEX=1, no further GO high.
REQ-035 SHALL cover RESET pulsed low during WAIT_END -> all outputs at reset values the next cycle; a later START restarts at index 0.
REQ-036 SHALL cover, with I2C_SEQ_TIMEOUT_EN defined, END held high forever -> ERROR=1 after 1024 cycles in RUN, ERR_INDEX=0.
